tcp_csum_fixup: RTL and testbench

Store-and-forward AXI-Stream stage placed directly downstream of the NAT connection-table stage. That stage overwrites the TCP destination port with a connection ID and leaves the TCP checksum stale. This block buffers one frame, recomputes the TCP checksum over the pseudo-header and segment, and re-emits the frame with bytes 58–59 corrected. Non-TCP frames, frames with IP options, and frames shorter than 8 beats pass through unmodified.

---
 rtl/tcp_csum_fixup.sv | 203 ++++++++++++++++++++
 tb/tb_tcp_csum_fixup.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_csum_fixup.sv
// Store-and-forward TCP checksum repair after the NAT connection-table stage.
// Buffers one frame, recomputes the TCP checksum and patches frame bytes 58-59.
module tcp_csum_fixup #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] fixed_cnt,
    output logic [31:0] drop_cnt
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] FULL = PW'(DEPTH);
    localparam logic [16:0] MAX_TL = 17'(DEPTH * 8 - 22);

    typedef enum logic [1:0] {RECV, FOLD, SEND} state_t;

    state_t        r_state;
    logic [72:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_ovf;
    logic          r_eth;
    logic          r_ihl;
    logic          r_tcp;
    logic [15:0]   r_tlen;
    logic [31:0]   r_acc;
    logic [15:0]   r_csum;
    logic          r_elig;
    logic          r_s_tready;
    logic          r_m_tvalid;
    logic          r_m_tlast;
    logic [63:0]   r_m_tdata;
    logic [7:0]    r_m_tkeep;
    logic [31:0]   r_fixed;
    logic [31:0]   r_drop;

    logic          w_hs;
    logic          w_wr;
    logic [16:0]   w_end;
    logic [31:0]   w_add;
    logic [31:0]   w_s1;
    logic [16:0]   w_s2;
    logic [15:0]   w_s3;
    logic          w_elig;
    logic [72:0]   w_rd;
    logic [63:0]   w_rd_data;

    assign w_hs  = (r_state == RECV) && s_axis_tvalid && r_s_tready;
    assign w_wr  = w_hs && (r_wr_ptr != FULL);
    assign w_end = 17'd22 + {1'b0, r_tlen};

    // Words are summed only inside [34, 22+total_len), skipping the checksum field.
    always_comb begin
        logic [16:0] b;
        logic [15:0] word;
        b     = '0;
        word  = '0;
        w_add = '0;
        for (int j = 0; j < 4; j++) begin
            b    = 17'({r_wr_ptr, 3'b000}) + 17'(2 * j);
            word = {s_axis_tdata[16*j +: 8], s_axis_tdata[16*j+8 +: 8]};
            if (b + 17'd1 == w_end) word[7:0] = 8'h00;
            if (b >= 17'd34 && b < w_end && b != 17'd58)
                w_add = w_add + {16'b0, word};
        end
    end

    assign w_s1 = r_acc + 32'd6 + ({16'b0, r_tlen} - 32'd20);
    assign w_s2 = {1'b0, w_s1[15:0]} + {1'b0, w_s1[31:16]};
    assign w_s3 = w_s2[15:0] + {15'b0, w_s2[16]};

    assign w_elig = r_eth && r_ihl && r_tcp
                 && (r_wr_ptr >= PW'(8))
                 && (r_tlen >= 16'd40)
                 && ({1'b0, r_tlen} <= MAX_TL);

    assign w_rd = r_mem[r_rd_ptr[IW-1:0]];

    always_comb begin
        w_rd_data = w_rd[63:0];
        if (r_elig && r_rd_ptr == PW'(7))
            w_rd_data[31:16] = {r_csum[7:0], r_csum[15:8]};
    end

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr[IW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RECV;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ovf      <= 1'b0;
            r_eth      <= 1'b0;
            r_ihl      <= 1'b0;
            r_tcp      <= 1'b0;
            r_tlen     <= '0;
            r_acc      <= '0;
            r_csum     <= '0;
            r_elig     <= 1'b0;
            r_s_tready <= 1'b0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_fixed    <= '0;
            r_drop     <= '0;
        end else begin
            unique case (r_state)
                RECV: begin
                    r_s_tready <= 1'b1;
                    if (w_wr) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        r_acc    <= r_acc + w_add;
                        if (r_wr_ptr == PW'(2)) begin
                            r_eth <= (s_axis_tdata[39:32] == 8'h08)
                                  && (s_axis_tdata[47:40] == 8'h00);
                            r_ihl <= (s_axis_tdata[55:48] == 8'h45);
                        end
                        if (r_wr_ptr == PW'(3)) begin
                            r_tlen <= {s_axis_tdata[7:0], s_axis_tdata[15:8]};
                            r_tcp  <= (s_axis_tdata[63:56] == 8'h06);
                        end
                    end
                    if (w_hs && !w_wr)
                        r_ovf <= 1'b1;
                    if (w_hs && s_axis_tlast) begin
                        if (r_ovf || !w_wr) begin
                            r_drop   <= r_drop + 32'd1;
                            r_wr_ptr <= '0;
                            r_ovf    <= 1'b0;
                            r_acc    <= '0;
                            r_eth    <= 1'b0;
                            r_ihl    <= 1'b0;
                            r_tcp    <= 1'b0;
                            r_tlen   <= '0;
                        end else begin
                            r_state    <= FOLD;
                            r_s_tready <= 1'b0;
                        end
                    end
                end
                FOLD: begin
                    r_csum     <= ~w_s3;
                    r_elig     <= w_elig;
                    if (w_elig)
                        r_fixed <= r_fixed + 32'd1;
                    r_m_tvalid <= 1'b1;
                    r_m_tdata  <= w_rd_data;
                    r_m_tkeep  <= w_rd[71:64];
                    r_m_tlast  <= w_rd[72];
                    r_rd_ptr   <= r_rd_ptr + 1'b1;
                    r_state    <= SEND;
                end
                SEND: begin
                    if (r_m_tvalid && m_axis_tready) begin
                        if (r_rd_ptr == r_wr_ptr) begin
                            r_m_tvalid <= 1'b0;
                            r_s_tready <= 1'b1;
                            r_state    <= RECV;
                            r_wr_ptr   <= '0;
                            r_rd_ptr   <= '0;
                            r_acc      <= '0;
                            r_ovf      <= 1'b0;
                            r_eth      <= 1'b0;
                            r_ihl      <= 1'b0;
                            r_tcp      <= 1'b0;
                            r_tlen     <= '0;
                            r_elig     <= 1'b0;
                        end else begin
                            r_m_tdata <= w_rd_data;
                            r_m_tkeep <= w_rd[71:64];
                            r_m_tlast <= w_rd[72];
                            r_rd_ptr  <= r_rd_ptr + 1'b1;
                        end
                    end
                end
                default: r_state <= RECV;
            endcase
        end
    end

    assign s_axis_tready = r_s_tready;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tkeep  = r_m_tkeep;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tvalid = r_m_tvalid;
    assign fixed_cnt     = r_fixed;
    assign drop_cnt      = r_drop;
endmodule

// File: tb/tb_tcp_csum_fixup.sv
// Bench for tcp_csum_fixup: directed table, stall/overflow/reset sequences
// and random frames against an RFC 793 style checksum model.
module tb_tcp_csum_fixup;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = '0;
    logic        s_tlast = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [31:0] fixed_cnt;
    logic [31:0] drop_cnt;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;

    tcp_csum_fixup #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
        .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
        .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .fixed_cnt(fixed_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    logic [7:0] fin[$];
    logic [7:0] fexp[$];
    logic [7:0] out_q[$];
    int exp_fix_m;
    int out_frames = 0;
    int first_valid_cyc = -1;
    int end_cyc = -1;
    int tlast_cyc = 0;
    int stalls = 0;
    int rdy_mode = 0;
    int pat = 0;
    logic hold_v = 1'b0;
    logic [72:0] hold_b;

    // Output side: drive ready, check stall stability, collect bytes.
    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
            m_tready = 1'b1;
        end else begin
            if (rdy_mode == 0) m_tready = 1'b1;
            else if (rdy_mode == 1) m_tready = (pat % 4 == 0) || (pat % 4 == 3);
            else m_tready = ($urandom % 3) != 0;
            pat++;
            if (hold_v)
                chk("stall hold", {m_tvalid, m_tlast, m_tkeep, m_tdata}, {1'b1, hold_b});
            if (m_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (end_cyc >= 0 && cyc == end_cyc + 1) begin
                chk("s_tready after send", 64'(s_tready), 64'd1);
                chk("m_tvalid drop", 64'(m_tvalid), 64'd0);
            end
            hold_v = m_tvalid && !m_tready;
            hold_b = {m_tlast, m_tkeep, m_tdata};
            if (m_tvalid && m_tready) begin
                for (int k = 0; k < 8; k++)
                    if (m_tkeep[k]) out_q.push_back(m_tdata[8*k +: 8]);
                if (m_tlast) begin
                    out_frames++;
                    end_cyc = cyc;
                end
            end
        end
    end

    function automatic logic [7:0] fb(int i);
        return (i < fin.size()) ? fin[i] : 8'h00;
    endfunction

    // Reference: classify, then ones'-complement sum of pseudo-header + segment.
    function automatic void build_exp();
        int tl;
        longint s;
        logic [15:0] cs;
        fexp = fin;
        exp_fix_m = 0;
        if (fin.size() < 57) return;
        tl = int'({fb(24), fb(25)});
        if (!(fb(20) == 8'h08 && fb(21) == 8'h00 && fb(22) == 8'h45 &&
              fb(31) == 8'h06 && tl >= 40 && tl <= DEPTH * 8 - 22)) return;
        exp_fix_m = 1;
        s = 6 + (tl - 20);
        for (int i = 34; i < 42; i += 2) s += longint'({fb(i), fb(i + 1)});
        for (int i = 42; i < 22 + tl; i += 2)
            if (i != 58)
                s += (i + 1 < 22 + tl) ? longint'({fb(i), fb(i + 1)})
                                       : longint'({fb(i), 8'h00});
        while (s > 64'hFFFF) s = (s & 64'hFFFF) + (s >> 16);
        cs = ~s[15:0];
        fexp[58] = cs[15:8];
        fexp[59] = cs[7:0];
    endfunction

    task automatic send(input int lim_in);
        int nb;
        int lim;
        int w;
        logic [63:0] d;
        logic [7:0] k;
        nb = (fin.size() + 7) / 8;
        lim = (lim_in < 0) ? nb : lim_in;
        for (int b = 0; b < lim; b++) begin
            d = '0;
            k = '0;
            for (int l = 0; l < 8; l++)
                if (b * 8 + l < fin.size()) begin
                    d[8*l +: 8] = fin[b * 8 + l];
                    k[l] = 1'b1;
                end
            @(negedge clk);
            s_tdata = d;
            s_tkeep = k;
            s_tlast = (b == nb - 1);
            s_tvalid = 1'b1;
            w = 0;
            while (!s_tready && w < 100) begin
                stalls++;
                @(negedge clk);
                w++;
            end
            if (!s_tready) chk("input timeout", 64'd0, 64'd1);
            if (b == nb - 1) tlast_cyc = cyc;
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
    endtask

    task automatic run_frame(input string nm);
        int prev;
        int w;
        int nmis;
        logic [31:0] fix0;
        prev = out_frames;
        fix0 = fixed_cnt;
        build_exp();
        out_q.delete();
        first_valid_cyc = -1;
        send(-1);
        w = 0;
        while (out_frames == prev && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (out_frames == prev) chk({nm, " output timeout"}, 64'd0, 64'd1);
        @(negedge clk);
        nmis = 0;
        for (int i = 0; i < fexp.size() && i < out_q.size(); i++)
            if (out_q[i] !== fexp[i]) nmis++;
        chk({nm, " length"}, 64'(out_q.size()), 64'(fexp.size()));
        chk({nm, " bytes"}, 64'(nmis), 64'd0);
        chk({nm, " latency"}, 64'(first_valid_cyc - tlast_cyc), 64'd2);
        chk({nm, " fixed delta"}, 64'(fixed_cnt - fix0), 64'(exp_fix_m));
    endtask

    typedef struct {
        string       name;
        int          nbytes;
        logic [7:0]  et1;
        logic [7:0]  ihl;
        logic [15:0] tl;
        int          p1;
        logic [7:0]  v1;
        int          p2;
        logic [7:0]  v2;
        logic [15:0] exp_cs;
        int          exp_fix;
    } vec_t;

    function automatic vec_t mk(string n, int nb, logic [7:0] e, logic [7:0] ih,
                                logic [15:0] t, int a1, logic [7:0] b1,
                                int a2, logic [7:0] b2, logic [15:0] cs, int fx);
        vec_t v;
        v.name = n; v.nbytes = nb; v.et1 = e; v.ihl = ih; v.tl = t;
        v.p1 = a1; v.v1 = b1; v.p2 = a2; v.v2 = b2; v.exp_cs = cs; v.exp_fix = fx;
        return v;
    endfunction

    task automatic make_tcp(input int nb, input logic [7:0] e, input logic [7:0] ih,
                            input logic [15:0] t);
        fin.delete();
        for (int i = 0; i < nb; i++) fin.push_back(8'h00);
        fin[20] = 8'h08; fin[21] = e; fin[22] = ih;
        fin[24] = t[15:8]; fin[25] = t[7:0]; fin[31] = 8'h06;
    endtask

    vec_t vt[11];
    logic [31:0] fix0;

    initial begin
        vt[0]  = mk("min tcp",     62, 8'h00, 8'h45, 16'h0028, -1, 8'h00, -1, 8'h00, 16'hFFE5, 1);
        vt[1]  = mk("byte45",      62, 8'h00, 8'h45, 16'h0028, 45, 8'h01, -1, 8'h00, 16'hFFE4, 1);
        vt[2]  = mk("odd len",     64, 8'h00, 8'h45, 16'h0029, 62, 8'hAB, 63, 8'hCD, 16'h54E4, 1);
        vt[3]  = mk("arp",         64, 8'h06, 8'h45, 16'h0028, -1, 8'h00, -1, 8'h00, 16'h0000, 0);
        vt[4]  = mk("ip options",  64, 8'h00, 8'h46, 16'h0028, -1, 8'h00, -1, 8'h00, 16'h0000, 0);
        vt[5]  = mk("tl 39",       62, 8'h00, 8'h45, 16'h0027, -1, 8'h00, -1, 8'h00, 16'h0000, 0);
        vt[6]  = mk("7 beats",     56, 8'h00, 8'h45, 16'h0028, -1, 8'h00, -1, 8'h00, 16'h0000, 0);
        vt[7]  = mk("src ip",      62, 8'h00, 8'h45, 16'h0028, 34, 8'hC0, 35, 8'hA8, 16'h3F3D, 1);
        vt[8]  = mk("stale csum",  62, 8'h00, 8'h45, 16'h0028, 58, 8'h12, 59, 8'h34, 16'hFFE5, 1);
        vt[9]  = mk("max tl",    2048, 8'h00, 8'h45, 16'd2026, -1, 8'h00, -1, 8'h00, 16'hF823, 1);
        vt[10] = mk("tl over",   2048, 8'h00, 8'h45, 16'd2027, -1, 8'h00, -1, 8'h00, 16'h0000, 0);

        repeat (2) @(negedge clk);
        chk("rst s_tready", 64'(s_tready), 64'd0);
        chk("rst m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst m_tdata", m_tdata, 64'd0);
        chk("rst m_tkeep", 64'(m_tkeep), 64'd0);
        chk("rst m_tlast", 64'(m_tlast), 64'd0);
        chk("rst fixed_cnt", 64'(fixed_cnt), 64'd0);
        chk("rst drop_cnt", 64'(drop_cnt), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("s_tready after rst", 64'(s_tready), 64'd1);

        for (int t = 0; t < 11; t++) begin
            make_tcp(vt[t].nbytes, vt[t].et1, vt[t].ihl, vt[t].tl);
            if (vt[t].p1 >= 0) fin[vt[t].p1] = vt[t].v1;
            if (vt[t].p2 >= 0) fin[vt[t].p2] = vt[t].v2;
            fix0 = fixed_cnt;
            run_frame(vt[t].name);
            if (out_q.size() > 59)
                chk({vt[t].name, " csum"}, 64'({out_q[58], out_q[59]}),
                    64'(vt[t].exp_fix ? vt[t].exp_cs : {vt[t].v1, vt[t].v2} & 16'h0000));
            chk({vt[t].name, " fixed"}, 64'(fixed_cnt - fix0), 64'(vt[t].exp_fix));
        end

        rdy_mode = 1;
        make_tcp(120, 8'h00, 8'h45, 16'd98);
        for (int i = 32; i < 120; i++) fin[i] = 8'($urandom);
        run_frame("stall");
        rdy_mode = 0;

        stalls = 0;
        make_tcp(8 * (DEPTH + 3), 8'h00, 8'h45, 16'h0028);
        begin
            int prev;
            prev = out_frames;
            send(-1);
            repeat (10) @(negedge clk);
            chk("ovf no output", 64'(out_frames - prev), 64'd0);
            chk("ovf drop_cnt", 64'(drop_cnt), 64'd1);
            chk("ovf tready stalls", 64'(stalls), 64'd0);
        end
        make_tcp(62, 8'h00, 8'h45, 16'h0028);
        run_frame("after ovf");

        rdy_mode = 2;
        for (int r = 0; r < 25; r++) begin
            int len;
            len = $urandom_range(62, 320);
            fin.delete();
            for (int i = 0; i < len; i++) fin.push_back(8'($urandom));
            if ($urandom % 4 != 0) begin
                logic [15:0] tl;
                tl = 16'($urandom_range(40, len - 22));
                fin[20] = 8'h08; fin[21] = 8'h00; fin[22] = 8'h45;
                fin[24] = tl[15:8]; fin[25] = tl[7:0]; fin[31] = 8'h06;
            end
            run_frame("random");
        end
        rdy_mode = 0;

        make_tcp(80, 8'h00, 8'h45, 16'd58);
        send(4);
        rst = 1'b1;
        @(negedge clk);
        chk("mid rst m_tvalid", 64'(m_tvalid), 64'd0);
        chk("mid rst m_tdata", m_tdata, 64'd0);
        chk("mid rst fixed_cnt", 64'(fixed_cnt), 64'd0);
        chk("mid rst drop_cnt", 64'(drop_cnt), 64'd0);
        chk("mid rst s_tready", 64'(s_tready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid rst tready back", 64'(s_tready), 64'd1);
        for (int i = 32; i < 80; i++) fin[i] = 8'($urandom);
        run_frame("after rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
